adder_error_monitor: RTL and testbench

Downstream evaluation stage for the approximate adder prototypes. It samples each operand set (A, B, Cin) together with the DUT adder's result (S, Cout) under a valid/ready handshake and recomputes the exact sum internally. Over a programmed run length it accumulates error statistics: error count, summed error distance and maximum error distance. The outputs feed the literature-review error-metric tables (ER, MED, WCE).

---
 rtl/adder_eval_pkg.sv | 16 +
 rtl/adder_error_distance.sv | 24 ++
 rtl/adder_error_monitor.sv | 155 +++++++++++++++
 tb/tb_adder_error_monitor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_eval_pkg.sv
// Shared definitions for the approximate-adder evaluation stages:
// monitor state encoding and default widths.
package adder_eval_pkg;

    localparam int ADDER_WIDTH = 8;
    localparam int CNT_W       = 16;
    localparam int ACC_W       = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mon_state_e;

endpackage

// File: rtl/adder_error_distance.sv
// Combinational error distance between the exact sum a+b+cin and the
// approximate result {cout, s} reported by an adder under evaluation.
module adder_error_distance #(
    parameter int WIDTH = adder_eval_pkg::ADDER_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    output logic [WIDTH:0]   ed,
    output logic             is_err
);

    logic [WIDTH:0] exact;
    logic [WIDTH:0] approx;

    // Operands are zero-extended so the exact carry-out lands in the MSB.
    assign exact  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign approx = {cout, s};
    assign ed     = (exact >= approx) ? (exact - approx) : (approx - exact);
    assign is_err = (ed != '0);

endmodule

// File: rtl/adder_error_monitor.sv
// Samples operand/result sets from an approximate adder and accumulates
// error count, summed error distance (saturating) and worst-case distance.
module adder_error_monitor #(
    parameter int WIDTH = adder_eval_pkg::ADDER_WIDTH,
    parameter int CNT_W = adder_eval_pkg::CNT_W,
    parameter int ACC_W = adder_eval_pkg::ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] ed_sum,
    output logic [WIDTH:0]   ed_max,
    output logic             ed_sat
);
    import adder_eval_pkg::*;

    // MSB of the result flags that clamping occurred.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] sum,
                                               input logic [WIDTH:0]   ed);
        logic [ACC_W:0] raw;
        raw = {1'b0, sum} + {{(ACC_W-WIDTH){1'b0}}, ed};
        if (raw[ACC_W])
            sat_add = {1'b1, {ACC_W{1'b1}}};
        else
            sat_add = raw;
    endfunction

    mon_state_e       state;
    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] acc_cnt;
    logic             xfer;

    logic [WIDTH-1:0] a_p1, b_p1, s_p1;
    logic             cin_p1, cout_p1;
    logic             vld_p1;
    logic [WIDTH:0]   ed_p1;
    logic             is_err_p1;
    logic [ACC_W:0]   sum_next_p1;

    assign xfer = in_valid && in_ready;

    // Stage 1: capture the transferred sample.
    always_ff @(posedge clk) begin
        if (xfer) begin
            a_p1    <= a;
            b_p1    <= b;
            cin_p1  <= cin;
            s_p1    <= s;
            cout_p1 <= cout;
        end
    end

    adder_error_distance #(.WIDTH(WIDTH)) u_ed (
        .a      (a_p1),
        .b      (b_p1),
        .cin    (cin_p1),
        .s      (s_p1),
        .cout   (cout_p1),
        .ed     (ed_p1),
        .is_err (is_err_p1)
    );

    assign sum_next_p1 = sat_add(ed_sum, ed_p1);

    // Stage 2: fold the error distance into the stats; control FSM alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            num_lat    <= '0;
            acc_cnt    <= '0;
            vld_p1     <= 1'b0;
            sample_cnt <= '0;
            err_cnt    <= '0;
            ed_sum     <= '0;
            ed_max     <= '0;
            ed_sat     <= 1'b0;
        end else begin
            vld_p1 <= xfer;

            if (vld_p1) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
                err_cnt    <= err_cnt + CNT_W'(is_err_p1);
                ed_sum     <= sum_next_p1[ACC_W-1:0];
                if (sum_next_p1[ACC_W])
                    ed_sat <= 1'b1;
                if (ed_p1 > ed_max)
                    ed_max <= ed_p1;
            end

            case (state)
                IDLE, DONE: begin
                    // vld_p1 is always low here, so the clear cannot race an update.
                    if (start) begin
                        num_lat    <= num_samples;
                        acc_cnt    <= '0;
                        sample_cnt <= '0;
                        err_cnt    <= '0;
                        ed_sum     <= '0;
                        ed_max     <= '0;
                        ed_sat     <= 1'b0;
                        if (num_samples == '0) begin
                            state    <= DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                        if (acc_cnt + CNT_W'(1) == num_lat) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (!vld_p1) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_error_monitor.sv
// Directed bench for adder_error_monitor: single-sample vector table plus
// multi-cycle sequences for timing, handshake, control and saturation.
module tb_adder_error_monitor;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;
    localparam int ACC_W = 24;
    localparam int ACC_S = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic [WIDTH-1:0] a, b, s;
    logic             cin, cout;

    logic             in_ready, busy, done, ed_sat;
    logic [CNT_W-1:0] sample_cnt, err_cnt;
    logic [ACC_W-1:0] ed_sum;
    logic [WIDTH:0]   ed_max;

    logic             in_ready_s, busy_s, done_s, ed_sat_s;
    logic [CNT_W-1:0] sample_cnt_s, err_cnt_s;
    logic [ACC_S-1:0] ed_sum_s;
    logic [WIDTH:0]   ed_max_s;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    adder_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
        .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
        .ed_sum(ed_sum), .ed_max(ed_max), .ed_sat(ed_sat)
    );

    adder_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_S)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .cin(cin), .s(s), .cout(cout),
        .busy(busy_s), .done(done_s), .sample_cnt(sample_cnt_s), .err_cnt(err_cnt_s),
        .ed_sum(ed_sum_s), .ed_max(ed_max_s), .ed_sat(ed_sat_s)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [8:0] d;
        logic [8:0] exp_ed;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input int n);
        start       = 1'b1;
        num_samples = CNT_W'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        input logic [8:0] vd);
        int n;
        a = va; b = vb; cin = vc; {cout, s} = vd;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) check("send_ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    initial begin
        logic [8:0] e;
        int nx;

        tbl[0] = '{8'hFF, 8'h01, 1'b0, 9'h000, 9'd256};
        tbl[1] = '{8'h02, 8'h02, 1'b1, 9'd7,   9'd2};
        tbl[2] = '{8'h10, 8'h20, 1'b0, 9'h030, 9'd0};
        tbl[3] = '{8'h80, 8'h80, 1'b1, 9'h100, 9'd1};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 9'h1FF, 9'd511};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 9'h000, 9'd511};

        rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0; s = '0; cout = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stats", {sample_cnt, err_cnt, ed_sum, ed_max, ed_sat}, 0);

        // Single-sample runs from the table.
        for (int i = 0; i < 6; i++) begin
            do_start(1);
            send(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].d);
            wait_done();
            check($sformatf("tbl%0d_sample_cnt", i), sample_cnt, 1);
            check($sformatf("tbl%0d_err_cnt", i), err_cnt, (tbl[i].exp_ed != 0) ? 1 : 0);
            check($sformatf("tbl%0d_ed_sum", i), ed_sum, tbl[i].exp_ed);
            check($sformatf("tbl%0d_ed_max", i), ed_max, tbl[i].exp_ed);
        end

        // ED=256 followed by ED=2.
        do_start(2);
        send(8'hFF, 8'h01, 1'b0, 9'h000);
        send(8'h02, 8'h02, 1'b1, 9'd7);
        wait_done();
        check("pair_err_cnt", err_cnt, 2);
        check("pair_ed_sum", ed_sum, 258);
        check("pair_ed_max", ed_max, 256);

        // Exact model, 256 random samples, in_valid held high.
        do_start(256);
        check("start_in_ready", in_ready, 1);
        nx = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 400 && nx < 256; i++) begin
            logic acc;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            e = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            {cout, s} = e;
            acc = in_ready;
            tick();
            if (acc) nx++;
        end
        check("rand_xfers", nx, 256);
        check("rand_ready_T1", in_ready, 0);
        check("rand_done_T1", done, 0);
        tick();
        check("rand_done_T2", done, 0);
        check("rand_sample_cnt_T2", sample_cnt, 256);
        tick();
        check("rand_done_T3", done, 1);
        check("rand_busy_T3", busy, 0);
        check("rand_ready_T3", in_ready, 0);
        in_valid = 1'b0;
        check("rand_err_cnt", err_cnt, 0);
        check("rand_ed_sum", ed_sum, 0);
        check("rand_ed_max", ed_max, 0);

        // in_valid toggled 1-0-1-0; invalid cycles carry a bogus result.
        do_start(4);
        nx = 0;
        for (int i = 0; i < 12; i++) begin
            logic acc;
            in_valid = (i % 2 == 0);
            a = 8'd1; b = 8'd1; cin = 1'b0;
            {cout, s} = in_valid ? 9'd3 : 9'h0FF;
            acc = in_valid && in_ready;
            tick();
            if (acc) nx++;
        end
        in_valid = 1'b0;
        check("hs_xfers", nx, 4);
        wait_done();
        check("hs_sample_cnt", sample_cnt, 4);
        check("hs_err_cnt", err_cnt, 4);
        check("hs_ed_sum", ed_sum, 4);

        // Zero-length run clears previous stats and finishes at S+1.
        do_start(0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_stats", {sample_cnt, err_cnt, ed_sum, ed_max, ed_sat}, 0);

        // start during RUN is ignored.
        do_start(3);
        send(8'h02, 8'h02, 1'b1, 9'd7);
        do_start(0);
        check("runstart_busy", busy, 1);
        check("runstart_done", done, 0);
        check("runstart_ready", in_ready, 1);
        check("runstart_sample_cnt", sample_cnt, 1);
        send(8'h02, 8'h02, 1'b1, 9'd7);
        send(8'h02, 8'h02, 1'b1, 9'd7);
        wait_done();
        check("runstart_final_cnt", sample_cnt, 3);
        check("runstart_ed_sum", ed_sum, 6);

        // Saturation in the ACC_W=10 instance: 5 x 256 clamps at 1023.
        do_start(5);
        for (int i = 0; i < 5; i++) send(8'hFF, 8'h01, 1'b0, 9'h000);
        wait_done();
        check("sat_ed_sum", ed_sum_s, 1023);
        check("sat_flag", ed_sat_s, 1);
        check("nosat_ed_sum", ed_sum, 1280);
        check("nosat_flag", ed_sat, 0);
        do_start(0);
        check("sat_cleared", ed_sat_s, 0);
        check("sat_sum_cleared", ed_sum_s, 0);

        // Reset mid-run after 10 transfers.
        do_start(20);
        for (int i = 0; i < 10; i++) send(8'd1, 8'd1, 1'b0, 9'd3);
        rst = 1'b1;
        tick();
        check("midrst_ctrl", {in_ready, busy, done}, 0);
        check("midrst_stats", {sample_cnt, err_cnt, ed_sum, ed_max, ed_sat}, 0);
        rst = 1'b0;
        tick();
        check("midrst_idle", {in_ready, busy, done}, 0);
        do_start(3);
        for (int i = 0; i < 3; i++) send(8'd1, 8'd1, 1'b0, 9'd3);
        wait_done();
        check("after_rst_cnt", sample_cnt, 3);
        check("after_rst_err", err_cnt, 3);
        check("after_rst_sum", ed_sum, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
